// File: rtl/regression_sequencer.sv
// Front-end sequencer for the linear-regression coefficient engine.
// Buffers N (x,y) samples from an upstream valid/ready stream, replays the
// buffer twice into the engine (pass 0: sums/means, pass 1: deviations),
// waits for the engine handshake after each pass and captures B0/B1.
module regression_sequencer #(
  parameter int DW    = 20,
  parameter int DEPTH = 150,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] n_samples,
  input  logic          in_valid,
  input  logic [DW-1:0] in_x,
  input  logic [DW-1:0] in_y,
  output logic          in_ready,
  output logic          coef_en,
  output logic [DW-1:0] coef_x,
  output logic [DW-1:0] coef_y,
  output logic          coef_pass,
  output logic          coef_first,
  output logic          coef_last,
  input  logic          coef_done,
  input  logic [DW-1:0] coef_B0,
  input  logic [DW-1:0] coef_B1,
  output logic [DW-1:0] B0,
  output logic [DW-1:0] B1,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Buffer address width; pointers never exceed N-1 <= DEPTH-1.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } sample_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, PASS0, WAIT0, PASS1, WAIT1, DONE
  } state_t;

  state_t        state;
  sample_t       mem [DEPTH];
  sample_t       rd_word;
  logic [CW-1:0] n_lat;
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          wr_en;
  logic          wr_last;
  logic          rd_last;
  logic          start_ok;

  assign start_ok = (n_samples != '0) && (n_samples <= CW'(DEPTH));
  assign wr_en    = (state == LOAD) && in_valid && in_ready;
  assign wr_last  = (wr_ptr == n_lat - CW'(1));
  assign rd_last  = (rd_ptr == n_lat - CW'(1));
  assign rd_word  = mem[rd_ptr[AW-1:0]];

  // Sample buffer: written during LOAD only, contents survive between runs.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= '{x: in_x, y: in_y};
  end

  // Sequencer FSM with registered outputs; strobes default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      n_lat      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      in_ready   <= 1'b0;
      coef_en    <= 1'b0;
      coef_x     <= '0;
      coef_y     <= '0;
      coef_pass  <= 1'b0;
      coef_first <= 1'b0;
      coef_last  <= 1'b0;
      B0         <= '0;
      B1         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done       <= 1'b0;
      coef_en    <= 1'b0;
      coef_first <= 1'b0;
      coef_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              n_lat     <= n_samples;
              err       <= 1'b0;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              coef_pass <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              state     <= LOAD;
            end else begin
              // Bad count: flag it and complete immediately, results untouched.
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (wr_en) begin
            if (wr_last) begin
              // Pointer holds at N-1 so it never runs past the run length.
              in_ready <= 1'b0;
              rd_ptr   <= '0;
              state    <= PASS0;
            end else begin
              wr_ptr <= wr_ptr + CW'(1);
            end
          end
        end
        PASS0, PASS1: begin
          coef_en    <= 1'b1;
          coef_x     <= rd_word.x;
          coef_y     <= rd_word.y;
          coef_first <= (rd_ptr == '0);
          coef_last  <= rd_last;
          if (rd_last) begin
            rd_ptr <= '0;
            state  <= (state == PASS0) ? WAIT0 : WAIT1;
          end else begin
            rd_ptr <= rd_ptr + CW'(1);
          end
        end
        WAIT0: begin
          if (coef_done) begin
            coef_pass <= 1'b1;
            rd_ptr    <= '0;
            state     <= PASS1;
          end
        end
        WAIT1: begin
          // done rises together with the B0/B1 update and lasts the DONE cycle.
          if (coef_done) begin
            B0    <= coef_B0;
            B1    <= coef_B1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          coef_pass <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          in_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/regression_sequencer.md
Name: regression_sequencer

Overview:
- Front-end controller for the linear-regression coefficient engine.
- Buffers N (x,y) samples from an upstream valid/ready stream, then replays the buffer twice into the engine: pass 0 for sums/means, pass 1 for deviation products.
- Waits for the engine's completion handshake after each pass, captures B0/B1, and reports done.

Parameters:
- DW, 20, sample and coefficient width in bits.
- DEPTH, 150, maximum samples held in the internal buffer.
- CW, $clog2(DEPTH+1), width of the sample count and address counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- n_samples  in  CW  sample count for the run; latched on accepted start.
- in_valid  in  1  upstream sample valid.
- in_x, in_y  in  DW  upstream sample.
- in_ready  out  1  sequencer accepts a sample this cycle.
- coef_en  out  1  sample strobe to the engine.
- coef_x, coef_y  out  DW  replayed sample.
- coef_pass  out  1  0 = first pass, 1 = second pass.
- coef_first, coef_last  out  1  qualify first/last sample of a pass.
- coef_done  in  1  engine finished the current pass (one-cycle pulse).
- coef_B0, coef_B1  in  DW  engine results; valid on coef_done while coef_pass=1.
- B0, B1  out  DW  captured coefficients.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when B0/B1 update.
- err  out  1  sticky: start with n_samples=0 or n_samples>DEPTH; cleared by next accepted start.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; outputs in_ready, coef_en, coef_pass, coef_first, coef_last, busy, done, err = 0; B0, B1, coef_x, coef_y = 0; counters = 0. Buffer contents undefined.
- States: IDLE, LOAD, PASS0, WAIT0, PASS1, WAIT1, DONE.
- IDLE:
  - start with 1 <= n_samples <= DEPTH: latch N, clear err, wr_ptr=0, go to LOAD.
  - start with an invalid n_samples: set err, raise done for one cycle, stay IDLE; B0/B1 unchanged.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: write {x,y} to buf[wr_ptr], increment wr_ptr.
  - The cycle the Nth sample is written: in_ready drops next cycle; go to PASS0 with rd_ptr=0.
  - No back-pressure gaps are required; arbitrary in_valid gaps are tolerated.
- PASS0 / PASS1:
  - One sample per cycle. coef_en=1, coef_x/coef_y=buf[rd_ptr] (registered outputs), coef_first=(rd_ptr==0), coef_last=(rd_ptr==N-1).
  - Exactly N consecutive coef_en cycles per pass; then go to WAIT0 / WAIT1 with coef_en=0.
  - coef_pass holds its value through the pass and the following WAIT state.
- WAIT0: on coef_done, go to PASS1 (rd_ptr=0, coef_pass=1).
- WAIT1: on coef_done, capture B0<=coef_B0 and B1<=coef_B1, go to DONE.
- coef_done outside WAIT0/WAIT1 is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. The buffer is not cleared.
- start while busy is ignored: no err, no latch.
- N=1: coef_first and coef_last are both high on the single strobe.
- N=DEPTH: wr_ptr reaches DEPTH-1 with no wrap; the pointer never exceeds N-1.
- Latency, start to first coef_en: 1 (LOAD entry) + N accepted samples + 1 cycle.
- rst asserted mid-run aborts immediately to IDLE with all outputs reset. A partial run never asserts done.
- The sequencer does no arithmetic; all values pass through unchanged in width.

Test Plan:
- Reset mid-PASS0 (N=3, after the 2nd strobe) -> coef_en=0 asynchronously, busy=0, B0=B1=0, no done.
- start, n_samples=3; feed (1,3),(2,5),(3,7) back-to-back; engine model pulses coef_done 4 cycles after each pass and returns B0=1, B1=2 ->
  - two bursts of exactly 3 coef_en cycles in identical order;
  - coef_pass 0 then 1; coef_first/coef_last on samples 1 and 3;
  - B0=1, B1=2, one done pulse.
- Same run with in_valid deasserted every other cycle -> identical coef stream; in_ready low after the 3rd sample.
- start with n_samples=0, then with n_samples=DEPTH+1 -> err=1 and a done pulse each time, busy stays 0; a following valid start clears err.
- n_samples=DEPTH=150 with an early coef_done during PASS0 -> the early pulse is ignored; 150 strobes per pass; the last has coef_last=1.
- start pulsed during WAIT1 with n_samples=5 -> ignored; the run completes with the original N; the next IDLE start works.
